// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor: saturating per-channel access/miss counters with
// snapshot shadow registers and a registered readout mux.
module cache_perf_monitor #(
  parameter int NCH   = 3,
  parameter int CNT_W = 16,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             snap,
  input  logic [NCH-1:0]   acc_req,
  input  logic [NCH-1:0]   acc_stall,
  input  logic [NCH-1:0]   miss_req,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] rd_acc,
  output logic [CNT_W-1:0] rd_miss,
  output logic [CNT_W-1:0] rd_cycles,
  output logic             rd_ovf,
  output logic             rd_valid
);
  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [SEL_W:0]   NCH_L = (SEL_W+1)'(NCH);
  logic [CNT_W-1:0] acc_q [NCH];
  logic [CNT_W-1:0] acc_d [NCH];
  logic [CNT_W-1:0] miss_q [NCH];
  logic [CNT_W-1:0] miss_d [NCH];
  logic [CNT_W-1:0] sacc_q [NCH];
  logic [CNT_W-1:0] smiss_q [NCH];
  logic [CNT_W-1:0] cyc_q, cyc_d, scyc_q;
  logic [CNT_W-1:0] rd_acc_q, rd_acc_d, rd_miss_q, rd_miss_d, rd_cyc_q;
  logic [NCH-1:0]   ovf_q, ovf_d, sovf_q, prev_q, acc_ev, miss_ev;
  logic             snapped_q, rd_ovf_q, rd_ovf_d, rd_valid_q, sel_ok;
  assign acc_ev  = {NCH{en}} & acc_req & ~acc_stall;
  assign miss_ev = {NCH{en}} & miss_req & ~prev_q;
  assign sel_ok  = {1'b0, sel} < NCH_L;
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      acc_d[i]  = clr ? '0 : acc_q[i] + CNT_W'(acc_ev[i] && acc_q[i] != MAX);
      miss_d[i] = clr ? '0 : miss_q[i] + CNT_W'(miss_ev[i] && miss_q[i] != MAX);
      ovf_d[i]  = !clr && (ovf_q[i] || (acc_ev[i] && acc_q[i] == MAX) || (miss_ev[i] && miss_q[i] == MAX));
    end
    cyc_d     = clr ? '0 : cyc_q + CNT_W'(en && cyc_q != MAX);
    rd_acc_d  = sel_ok ? sacc_q[sel] : '0;
    rd_miss_d = sel_ok ? smiss_q[sel] : '0;
    rd_ovf_d  = sel_ok && sovf_q[sel];
  end
  // prev_q tracks miss_req unconditionally so re-enabling never fakes a miss edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '{default: '0};
      miss_q     <= '{default: '0};
      sacc_q     <= '{default: '0};
      smiss_q    <= '{default: '0};
      cyc_q      <= '0;
      scyc_q     <= '0;
      ovf_q      <= '0;
      sovf_q     <= '0;
      prev_q     <= '0;
      snapped_q  <= 1'b0;
      rd_acc_q   <= '0;
      rd_miss_q  <= '0;
      rd_cyc_q   <= '0;
      rd_ovf_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      miss_q     <= miss_d;
      cyc_q      <= cyc_d;
      ovf_q      <= ovf_d;
      prev_q     <= miss_req;
      if (snap) begin
        sacc_q  <= acc_q;
        smiss_q <= miss_q;
        scyc_q  <= cyc_q;
        sovf_q  <= ovf_q;
      end
      snapped_q  <= snapped_q | snap;
      rd_acc_q   <= rd_acc_d;
      rd_miss_q  <= rd_miss_d;
      rd_cyc_q   <= scyc_q;
      rd_ovf_q   <= rd_ovf_d;
      rd_valid_q <= snapped_q;
    end
  end
  assign rd_acc    = rd_acc_q;
  assign rd_miss   = rd_miss_q;
  assign rd_cycles = rd_cyc_q;
  assign rd_ovf    = rd_ovf_q;
  assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb_cache_perf_monitor: directed plan plus random traffic checked against
// an event-counting reference model (unbounded counts, saturated on readout).
module tb_cache_perf_monitor;
  localparam int NCH = 3, MAXV = 255;
  logic clk = 0, rst = 1, en = 0, clr = 0, snap = 0;
  logic [2:0] acc_req = 0, acc_stall = 0, miss_req = 0;
  logic [1:0] sel = 0;
  logic [7:0] rd_acc, rd_miss, rd_cycles;
  logic rd_ovf, rd_valid;
  int compared = 0, mismatched = 0;
  int acc_n[3], miss_n[3], cyc_n, s_acc[3], s_miss[3], s_cyc, e_acc, e_miss, e_cyc;
  bit prev[3], s_ovf[3], s_valid, e_ovf, e_valid;

  always #5 clk = ~clk;

  cache_perf_monitor #(.NCH(3), .CNT_W(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .snap(snap),
    .acc_req(acc_req), .acc_stall(acc_stall), .miss_req(miss_req), .sel(sel),
    .rd_acc(rd_acc), .rd_miss(rd_miss), .rd_cycles(rd_cycles),
    .rd_ovf(rd_ovf), .rd_valid(rd_valid)
  );

  function automatic int sat(input int n);
    return n > MAXV ? MAXV : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      acc_n[i] = 0; miss_n[i] = 0; prev[i] = 0; s_acc[i] = 0; s_miss[i] = 0; s_ovf[i] = 0;
    end
    cyc_n = 0; s_cyc = 0; s_valid = 0;
    e_acc = 0; e_miss = 0; e_cyc = 0; e_ovf = 0; e_valid = 0;
  endtask

  task automatic model_edge();
    e_acc   = sel < NCH ? s_acc[sel] : 0;
    e_miss  = sel < NCH ? s_miss[sel] : 0;
    e_ovf   = sel < NCH ? s_ovf[sel] : 0;
    e_cyc   = s_cyc;
    e_valid = s_valid;
    if (snap) begin
      for (int i = 0; i < NCH; i++) begin
        s_acc[i] = sat(acc_n[i]); s_miss[i] = sat(miss_n[i]);
        s_ovf[i] = acc_n[i] > MAXV || miss_n[i] > MAXV;
      end
      s_cyc = sat(cyc_n); s_valid = 1;
    end
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin acc_n[i] = 0; miss_n[i] = 0; end
      cyc_n = 0;
    end else if (en) begin
      cyc_n++;
      for (int i = 0; i < NCH; i++) begin
        if (acc_req[i] && !acc_stall[i]) acc_n[i]++;
        if (miss_req[i] && !prev[i]) miss_n[i]++;
      end
    end
    for (int i = 0; i < NCH; i++) prev[i] = miss_req[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    acc_req = 0; acc_stall = 0; miss_req = 0; clr = 0; snap = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " acc"}, rd_acc, e_acc);
    chk({tag, " miss"}, rd_miss, e_miss);
    chk({tag, " cycles"}, rd_cycles, e_cyc);
    chk({tag, " ovf"}, rd_ovf, e_ovf);
    chk({tag, " valid"}, rd_valid, e_valid);
  endtask

  task automatic read_ch(input logic [1:0] s, input string tag);
    idle(); sel = s; tick(); check_model(tag);
  endtask

  task automatic do_snap();
    snap = 1; tick(); snap = 0;
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " acc"}, rd_acc, 0);
    chk({tag, " miss"}, rd_miss, 0);
    chk({tag, " cycles"}, rd_cycles, 0);
    chk({tag, " ovf"}, rd_ovf, 0);
    chk({tag, " valid"}, rd_valid, 0);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_zero("rst");
    rst = 0;
    en = 1;
    repeat (10) tick();
    en = 0;
    do_snap();
    read_ch(0, "idle");
    chk("idle cycles10", rd_cycles, 10);
    chk("idle valid1", rd_valid, 1);

    en = 1;
    do_clr();
    for (int k = 1; k <= 8; k++) begin
      acc_req = 3'b001; acc_stall = (k >= 3 && k <= 5) ? 3'b001 : 3'b000;
      tick();
    end
    idle(); do_snap();
    read_ch(0, "stall ch0"); chk("stall ch0 acc5", rd_acc, 5);
    read_ch(1, "stall ch1"); chk("stall ch1 acc0", rd_acc, 0);
    read_ch(2, "stall ch2"); chk("stall ch2 acc0", rd_acc, 0);

    do_clr();
    for (int k = 1; k <= 12; k++) begin
      miss_req = 3'b010; en = !(k >= 5 && k <= 7);
      tick();
    end
    en = 1; miss_req = 0; tick();
    miss_req = 3'b010; repeat (4) tick();
    idle(); do_snap();
    read_ch(1, "miss ch1"); chk("miss ch1 two", rd_miss, 2);

    do_clr();
    acc_req = 3'b100; repeat (300) tick();
    idle(); do_snap();
    read_ch(2, "sat ch2"); chk("sat acc255", rd_acc, 255); chk("sat ovf1", rd_ovf, 1);
    do_clr(); do_snap();
    read_ch(2, "satclr ch2"); chk("satclr acc0", rd_acc, 0); chk("satclr ovf0", rd_ovf, 0);

    do_clr();
    acc_req = 3'b001; repeat (7) tick();
    idle(); do_snap();
    acc_req = 3'b001; repeat (20) tick();
    read_ch(0, "iso hold"); chk("iso acc7", rd_acc, 7);
    snap = 1; clr = 1; tick();
    read_ch(0, "iso snapclr"); chk("iso acc27", rd_acc, 27);
    do_snap();
    read_ch(0, "iso live0"); chk("iso acc0", rd_acc, 0);

    acc_req = 3'b001; repeat (6) tick();
    idle(); do_snap();
    read_ch(0, "pre arst");
    miss_req = 3'b001;
    #2 rst = 1;
    #1 check_zero("arst");
    model_reset();
    @(posedge clk); #1 rst = 0;
    tick();
    chk("post arst valid0", rd_valid, 0);
    repeat (4) tick();
    miss_req = 0; acc_req = 3'b010; repeat (4) tick();
    idle(); do_snap();
    read_ch(0, "resume ch0"); chk("resume miss1", rd_miss, 1);
    read_ch(1, "resume ch1"); chk("resume acc4", rd_acc, 4);

    for (int k = 0; k < 500; k++) begin
      en = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 31) == 0;
      snap = $urandom_range(0, 3) == 0;
      acc_req = 3'($urandom); acc_stall = 3'($urandom); miss_req = 3'($urandom);
      sel = 2'($urandom);
      tick();
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cache_perf_monitor.md
# cache_perf_monitor

Synthesizable, parametrised cache-statistics unit for the CHIP cache subsystem. It counts processor accesses and miss-initiated memory requests on up to NCH cache ports (e.g. I-read, D-read, D-write). Results are held in saturating counters with snapshot shadow registers and a registered readout mux, so miss rates can be read from silicon or a gate-level run without hierarchical probes. It sits beside the caches inside CHIP and only observes; it never drives cache or memory handshakes.

## Interface
- NCH, 3, number of monitored channels (1..8)
- CNT_W, 16, width of every counter (8..32)
- SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NCH
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  counting enable
- clr  in  1  synchronous clear of live counters and overflow flags
- snap  in  1  copy live counters into shadow registers
- acc_req  in  NCH  per channel: processor access presented (proc_read or proc_write)
- acc_stall  in  NCH  per channel: cache stalling the processor
- miss_req  in  NCH  per channel: cache-to-memory request (mem_read / mem_write)
- sel  in  SEL_W  readout channel select
- rd_acc  out  CNT_W  shadow access count of channel sel
- rd_miss  out  CNT_W  shadow miss count of channel sel
- rd_cycles  out  CNT_W  shadow enabled-cycle count
- rd_ovf  out  1  shadow overflow flag of channel sel
- rd_valid  out  1  readout registers hold data from at least one snap

## Operation
- Per channel i, live state: acc_cnt[i], miss_cnt[i], ovf[i], miss_prev[i]. Global: cyc_cnt.
- Access event: acc_req[i] & ~acc_stall[i] in a cycle with en=1; adds 1 to acc_cnt[i].
- Miss event: miss_req[i] & ~miss_prev[i] with en=1; adds 1 to miss_cnt[i]. A request held high over many cycles counts once. It re-arms only after miss_req[i] is low for at least one cycle.
- miss_prev[i] <= miss_req[i] every cycle regardless of en or clr. Re-enabling mid-request therefore never produces a spurious miss.
- cyc_cnt adds 1 every cycle with en=1.
- Saturation: counters stop at 2**CNT_W-1. An event arriving at max sets ovf[i] (sticky). Saturation of cyc_cnt sets no flag.
- en=0: all live counters hold.
- clr=1: all live counters and ovf go to 0 next edge. Same-cycle events are discarded (clr wins over increment).
- snap=1: shadow registers load the current live register values, i.e. values before this cycle's update. snap together with clr captures pre-clear values. Shadows are unaffected by clr and are cleared only by rst.
- Readout registered: rd_* <= shadow[sel] each edge. sel >= NCH yields rd_acc=rd_miss=0 and rd_ovf=0; rd_cycles is still valid.
- rd_valid goes to 1 on the edge after the first snap and stays 1 until rst.

## Timing
- rst asserted: all live, shadow, miss_prev and rd_* registers = 0 immediately, including rd_valid=0.
- Event at edge N: live counter updated at edge N. snap at edge N+1 captures it. rd_* shows it at edge N+2 (sel stable).
- sel change at edge N: rd_* reflects the new channel after edge N+1 (1-cycle latency).
- rst deasserted mid-request (miss_req high): miss_prev=0 after reset, so the first edge out of reset counts one miss. This is intentional.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: rst pulse, then en=1 for 10 cycles with no events, snap, sel=0 -> rd_acc=0, rd_miss=0, rd_cycles=10, rd_valid=1, all outputs 0 during rst.
- Stall filtering: ch0 acc_req=1 for 8 cycles with acc_stall=1 on cycles 3-5 -> rd_acc=5 on ch0; ch1, ch2 read 0.
- Miss edge detect: ch1 miss_req high 12 cycles, low 1, high 4; en dropped mid-first pulse and restored -> rd_miss=2 on ch1.
- Saturation: CNT_W=8, ch2 gets 300 accesses -> rd_acc=255, rd_ovf=1. Then clr -> after snap rd_acc=0, rd_ovf=0.
- Snapshot isolation: snap, then 20 more accesses on ch0 without snap -> rd_acc unchanged. snap+clr same cycle -> shadow holds pre-clear count, live counts 0.
- Async reset mid-run: assert rst between edges while counters are nonzero -> all outputs 0 before the next clk edge. Counting resumes correctly after release.
